led_sched: RTL

Scheduler that shares the board's 4-LED bank (orange/green pair per LED) among multiple status requesters and a timed "identify" walk sequence. Each requester presents a lamp pattern and a blink flag; the block grants the LED bank to the highest-priority active requester, applies blink gating from a shared blink timebase, and drives the active-low LED pins. It sits between the status managers (QSFP link status, latched-error indicators, host commands) and the LED pins.

---
 rtl/led_sched.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/led_sched.sv
// LED bank scheduler: highest-index requester wins the 4-LED bank, with shared blink gating.
// Define LED_SCHED_IDENT_EN to build the timed identify walk (IDENT state); otherwise identify inputs are ignored.
module led_sched #(
    parameter int FREQ_HZ   = 250000000,
    parameter int NREQ      = 4,
    parameter int BLINK_DIV = FREQ_HZ / 4,
    parameter int STEP_DIV  = FREQ_HZ / 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [8*NREQ-1:0]   req_pattern,
    input  logic [NREQ-1:0]     req_blink,
    input  logic                ident_start,
    input  logic [3:0]          ident_loops,
    input  logic                ident_abort,
    output logic [NREQ-1:0]     grant,
    output logic                ident_busy,
    output logic [3:0]          led_orang_l,
    output logic [3:0]          led_green_l
);

    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [BW-1:0] BLINK_TC = BW'(BLINK_DIV - 1);

    logic [BW-1:0]   blink_cnt, blink_cnt_nxt;
    logic            blink_phase, blink_phase_nxt;
    logic [NREQ-1:0] arb_grant;
    logic [7:0]      arb_pat;
    logic            arb_blink;
    logic            in_ident_nxt;
    logic [7:0]      ident_pat;
    logic [7:0]      disp;

    // Free-running blink timebase, independent of arbitration and identify state.
    always_comb begin
        if (blink_cnt == BLINK_TC) begin
            blink_cnt_nxt   = '0;
            blink_phase_nxt = ~blink_phase;
        end else begin
            blink_cnt_nxt   = blink_cnt + 1'b1;
            blink_phase_nxt = blink_phase;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else begin
            blink_cnt   <= blink_cnt_nxt;
            blink_phase <= blink_phase_nxt;
        end
    end

    // NOTE: every variable gets a default before the loop so no latch is inferred.
    always_comb begin
        arb_grant = '0;
        arb_pat   = '0;
        arb_blink = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (req_valid[i]) begin
                arb_grant    = '0;
                arb_grant[i] = 1'b1;
                arb_pat      = req_pattern[8*i +: 8];
                arb_blink    = req_blink[i];
            end
        end
        if (arb_blink && !blink_phase_nxt)
            arb_pat = '0;
    end

`ifdef LED_SCHED_IDENT_EN
    localparam int TW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [TW-1:0] STEP_TC = TW'(STEP_DIV - 1);
    localparam logic [0:0] ST_ARB   = 1'b0;
    localparam logic [0:0] ST_IDENT = 1'b1;

    logic [0:0]    state, state_nxt;
    logic [2:0]    step, step_nxt;
    logic [TW-1:0] timer, timer_nxt;
    logic [3:0]    loops, loops_nxt;

    always_comb begin
        state_nxt = state;
        step_nxt  = step;
        timer_nxt = timer;
        loops_nxt = loops;
        case (state)
            ST_ARB: begin
                if (ident_start && !ident_abort && ident_loops != 4'd0) begin
                    state_nxt = ST_IDENT;
                    loops_nxt = ident_loops;
                    step_nxt  = '0;
                    timer_nxt = '0;
                end
            end
            default: begin
                if (ident_abort) begin
                    state_nxt = ST_ARB;
                    step_nxt  = '0;
                    timer_nxt = '0;
                end else if (timer == STEP_TC) begin
                    timer_nxt = '0;
                    if (step == 3'd7) begin
                        loops_nxt = loops - 4'd1;
                        step_nxt  = '0;
                        if (loops == 4'd1)
                            state_nxt = ST_ARB;
                    end else begin
                        step_nxt = step + 3'd1;
                    end
                end else begin
                    timer_nxt = timer + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_ARB;
            step  <= '0;
            timer <= '0;
            loops <= '0;
        end else begin
            state <= state_nxt;
            step  <= step_nxt;
            timer <= timer_nxt;
            loops <= loops_nxt;
        end
    end

    // Step s lights bit s of {orang, green}: green[0..3] then orange[0..3].
    assign in_ident_nxt = (state_nxt == ST_IDENT);
    assign ident_pat    = 8'd1 << step_nxt;
`else
    logic unused_ident;
    assign unused_ident = ^{ident_start, ident_abort, ident_loops};
    assign in_ident_nxt = 1'b0;
    assign ident_pat    = '0;
`endif

    assign disp = in_ident_nxt ? ident_pat : arb_pat;

    // NOTE: outputs register the next-state view so pins change on the same edge as the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            grant       <= '0;
            ident_busy  <= 1'b0;
            led_orang_l <= 4'hF;
            led_green_l <= 4'hF;
        end else begin
            grant       <= in_ident_nxt ? '0 : arb_grant;
            ident_busy  <= in_ident_nxt;
            led_orang_l <= ~disp[7:4];
            led_green_l <= ~disp[3:0];
        end
    end

endmodule
